register_file_nbit: RTL
=======================

Name: register_file_nbit

Overview:
- Parametrised multi-register storage for the CPU datapath: DEPTH registers of N bits each.
- One synchronous write port, two combinational read ports, and one in-place increment/decrement port for pointer-style registers (stack pointer, index).
- Replaces discrete single registers in the datapath where several general-purpose or pointer registers are needed.
- Adds a registered wrap flag for pointer overflow and underflow detection.

Parameters:
- N, 8, data width in bits (N >= 2).
- DEPTH, 4, number of registers (2..256); AW = max(1, clog2(DEPTH)) is a derived local parameter, not overridable.

Ports:
- clk  in  1  positive-edge clock
- rst  in  1  reset, asynchronous, active-high
- we  in  1  write enable
- waddr  in  AW  write register index
- wdata  in  N  write data
- ra_addr  in  AW  read port A index
- ra_data  out  N  read port A data
- rb_addr  in  AW  read port B index
- rb_data  out  N  read port B data
- inc  in  1  increment request
- dec  in  1  decrement request
- iaddr  in  AW  increment/decrement target index
- iwrap  out  1  registered wrap flag

Behaviour:
- Reset: all registers and iwrap go to 0 immediately on rst assertion. They hold 0 while rst is high, independent of clk.
- Write: on a posedge clk with we=1 and waddr<DEPTH, reg[waddr] <= wdata. With we=0 the register holds its value.
- Inc/dec: on a posedge clk with exactly one of inc/dec set and iaddr<DEPTH, reg[iaddr] <= reg[iaddr] ± 1, modulo 2^N.
  - inc=dec=1 is a no-op for the inc/dec port and iwrap stays 0.
- Wrap-around:
  - inc on all-ones -> register becomes 0.
  - dec on 0 -> register becomes all-ones.
  - iwrap is 1 for exactly the cycle after a wrapping edge, else 0.
  - iwrap is not set when a collision suppresses the operation (see next item).
- Collision: we=1 and inc/dec on the same index in the same cycle -> the write wins, inc/dec is discarded, iwrap=0. Different indices -> both take effect in the same edge.
- Out-of-range index (>= DEPTH, possible when DEPTH is not a power of 2):
  - writes and inc/dec are ignored;
  - reads return 0.
- Reads: purely combinational from the array, zero-cycle latency. A read shows the pre-edge value; data written at edge k is visible after edge k.
- Both read ports may address the same or any register independently.
- Reset mid-operation: a pending write or inc/dec in the cycle rst rises is lost. The first write that takes effect occurs at the first posedge after rst is released.

Optional Feature:
- Macro REGFILE_WRITE_BYPASS_EN.
- Defined: a read port whose address equals waddr while we=1 (and waddr<DEPTH) returns wdata combinationally, giving same-cycle forwarding.
  - Bypass applies to the write port only, not to inc/dec results.
- Undefined: reads always return the stored value. The storage update is identical in both builds.

Decomposition:
- Package regfile_pkg holds:
  - default width/depth constants (REGFILE_N_DEF=8, REGFILE_DEPTH_DEF=4);
  - a clog2 helper function;
  - the op-select encoding (OP_HOLD, OP_LOAD, OP_INC, OP_DEC).
- One sub-module, regfile_cell: a single N-bit register with async reset and an op-select input (hold/load/inc/dec) plus a wrap output.
  - The top level generates DEPTH instances and resolves write-vs-inc/dec priority into per-cell op selects.
  - The read muxes are built at the top level.

Test Plan:
- Assert rst mid-cycle after loading reg1=0xA5 -> all reads return 0x00 immediately and iwrap=0; a write at the first post-reset edge lands.
- we=1, waddr=2, wdata=0x3C; ra_addr=2 in the same cycle -> ra_data shows the old value 0x00 without bypass (0x3C with REGFILE_WRITE_BYPASS_EN); after the edge ra_data=0x3C.
- reg3=0xFF, inc=1, iaddr=3 -> reg3=0x00 and iwrap=1 for one cycle. Then dec on reg3 -> reg3=0xFF, iwrap=1 again.
- we=1, waddr=1, wdata=0x10 with inc=1, iaddr=1 (reg1=0x05) -> reg1=0x10, iwrap=0.
  - Repeat with iaddr=0 (reg0=0x07) -> reg1=0x10 and reg0=0x08 in the same edge.
- inc=dec=1 on reg0=0x00 -> reg0 stays 0x00, iwrap=0.
- DEPTH=3: write 0x55 to index 3 -> no register changes; ra_addr=3 -> 0x00. Read reg0 on both ports simultaneously -> rb_data=ra_data.

Source files
------------

// File: rtl/register_file_nbit_pkg.sv
// Shared constants, address-width helper and per-cell op-select encoding for
// the register file slice.
package regfile_pkg;

  localparam int REGFILE_N_DEF     = 8;
  localparam int REGFILE_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // A single-register file still needs a one-bit index.
  function automatic int addr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/register_file_nbit_if.sv
// Port bundle for register_file_nbit: write, two read and one inc/dec port.
interface register_file_nbit_if #(
  parameter int N     = 8,
  parameter int DEPTH = 4
);
  import regfile_pkg::*;

  localparam int AW = addr_width(DEPTH);

  // No handshake: every command (we, inc, dec) is a single-cycle strobe sampled
  // on the rising clock edge and is always accepted; reads are combinational.
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic [AW-1:0] ra_addr;
  logic [N-1:0]  ra_data;
  logic [AW-1:0] rb_addr;
  logic [N-1:0]  rb_data;
  logic          inc;
  logic          dec;
  logic [AW-1:0] iaddr;
  logic          iwrap;

  modport master (
    output we, waddr, wdata, ra_addr, rb_addr, inc, dec, iaddr,
    input  ra_data, rb_data, iwrap
  );

  modport slave (
    input  we, waddr, wdata, ra_addr, rb_addr, inc, dec, iaddr,
    output ra_data, rb_data, iwrap
  );

endinterface

// File: rtl/register_file_nbit_cell.sv
// One N-bit register with hold/load/inc/dec op select and a registered flag
// that marks an inc/dec that wrapped modulo 2^N.
module regfile_cell
  import regfile_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  op_e          op_i,
  input  logic [N-1:0] load_data_i,
  output logic [N-1:0] q_o,
  output logic         wrap_o
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    case (op_i)
      OP_LOAD: q_d = load_data_i;
      OP_INC: begin
        q_d    = q_q + ONE;
        wrap_d = &q_q;
      end
      OP_DEC: begin
        q_d    = q_q - ONE;
        wrap_d = ~|q_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q_o    = q_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/register_file_nbit.sv
// DEPTH x N register file with in-place inc/dec and registered wrap flag.
// Optional same-cycle write forwarding to the read ports: REGFILE_WRITE_BYPASS_EN.
module register_file_nbit
  import regfile_pkg::*;
#(
  parameter int N     = REGFILE_N_DEF,
  parameter int DEPTH = REGFILE_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  register_file_nbit_if.slave   bus
);

  localparam int AW = addr_width(DEPTH);

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [N-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] wrap;
  logic [DEPTH-1:0] wr_hit;
  logic             incdec_one;
  logic [N-1:0]     ra, rb;

  // inc and dec together cancel out and never reach a cell.
  assign incdec_one = bus.inc ^ bus.dec;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    localparam logic [AW-1:0] IDX = AW'(i);
    op_e op_sel;

    assign wr_hit[i] = bus.we && (bus.waddr == IDX);

    // Write wins over inc/dec on the same index, which also suppresses wrap.
    always_comb begin
      op_sel = OP_HOLD;
      if (wr_hit[i]) op_sel = OP_LOAD;
      else if (incdec_one && (bus.iaddr == IDX)) op_sel = bus.inc ? OP_INC : OP_DEC;
    end

    regfile_cell #(.N(N)) u_cell (
      .clk         (clk),
      .rst         (rst),
      .op_i        (op_sel),
      .load_data_i (bus.wdata),
      .q_o         (regs[i]),
      .wrap_o      (wrap[i])
    );
  end

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    ra = '0;
    rb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.ra_addr == AW'(i)) ra = regs[i];
      if (bus.rb_addr == AW'(i)) rb = regs[i];
    end
    if (BYPASS_EN && (|wr_hit) && (bus.waddr == bus.ra_addr)) ra = bus.wdata;
    if (BYPASS_EN && (|wr_hit) && (bus.waddr == bus.rb_addr)) rb = bus.wdata;
  end

  assign bus.ra_data = ra;
  assign bus.rb_data = rb;
  // At most one cell performs inc/dec per edge, so OR-ing is exact.
  assign bus.iwrap   = |wrap;

endmodule
